sdram_chip_model: RTL and testbench

- Synthesizable cycle-level responder for the 16-bit single-chip SDRAM pin interface; the device end that the SNES sdram controller drives.
- Decodes commands, tracks per-bank row state, returns read data after CAS latency with DQM masking, and writes a small backing array.
- Checks protocol timing and flags violations in sticky error bits.
- Used in the controller simulation bench and in FPGA loopback self-tests.

---
 rtl/sdram_chip_model_if.sv | 26 ++
 rtl/sdram_chip_model.sv | 249 ++++++++++++++++++++++++
 tb/tb_sdram_chip_model.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_chip_model_if.sv
// Pin-level bus between an SDRAM controller (master) and the chip model (slave).
// Carries the command strobes, multiplexed address, bank, byte masks and the
// split data bus (dq_in towards the chip, dq_out/dq_oe back to the controller).
interface sdram_chip_model_if;
  logic        sd_ncs;
  logic        sd_nras;
  logic        sd_ncas;
  logic        sd_nwe;
  logic [12:0] sd_a;
  logic [1:0]  sd_ba;
  logic        sd_dqml;
  logic        sd_dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic [1:0]  dq_oe;

  modport master (
    output sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_a, sd_ba, sd_dqml, sd_dqmh, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_a, sd_ba, sd_dqml, sd_dqmh, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/sdram_chip_model.sv
// Cycle-level responder for a 16-bit single-chip SDRAM: decodes commands,
// tracks per-bank row state, returns read data after CAS latency with DQM
// masking, writes a small aliased backing array and flags timing violations.
// Ports: clk, reset (sync, active-high); sd (slave modport: command/address/
// DQM/dq_in in, dq_out/dq_oe out); init_done; err[7:0] sticky flags;
// refresh_count.
// Build option: define SDRAM_CHIP_MODEL_STRICT_EN to discard any command that
// raises err[0], err[1], err[3], err[4] or err[5] instead of executing it.
module sdram_chip_model #(
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned T_RCD     = 3,
  parameter int unsigned T_RRD     = 2,
  parameter int unsigned T_RC      = 8,
  parameter int unsigned T_RP      = 3,
  parameter int unsigned T_WR      = 2,
  parameter int unsigned T_REF_MAX = 1100
) (
  input  logic               clk,
  input  logic               reset,
  sdram_chip_model_if.slave  sd,
  output logic               init_done,
  output logic [7:0]         err,
  output logic [15:0]        refresh_count
);
  localparam int unsigned NB = 4;
  // Timing counters saturate, so they only need to exceed the largest tXX.
  localparam int unsigned CW = 8;
  localparam int unsigned RW = $clog2(T_REF_MAX + 2);

  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS} cmd_t;
  typedef enum logic [1:0] {B_IDLE, B_ACTIVE, B_PRECHG} bank_st_t;

  bank_st_t      bank_st  [NB];
  logic [12:0]   bank_row [NB];
  logic [NB-1:0] ap_pend;
  logic [CW-1:0] ap_cnt   [NB];
  logic [CW-1:0] pre_cnt  [NB];
  logic [CW-1:0] act_age  [NB];
  logic [CW-1:0] rrd_age;
  logic [1:0]    last_ba;
  logic          cl3;
  logic [RW-1:0] ref_age;
  logic [2:0]    p_v;
  logic [15:0]   p_d [3];
  logic [1:0]    p_m [3];
  logic          out_v;
  logic [15:0]   mem [2**MEM_AW];

  cmd_t              cmd_c;
  logic [1:0]        ba_c;
  logic [1:0]        dqm_c;
  logic              rw_c;
  logic              mode_ok_c;
  logic              exec_c;
  logic              rd_exec_c;
  logic              wr_exec_c;
  logic [NB-1:0]     bank_idle_c;
  logic [7:0]        viol_c;
  logic [MEM_AW-1:0] idx_c;
  logic [15:0]       rd_word_c;
  logic              src_v_c;
  logic [15:0]       src_d_c;
  logic [1:0]        src_m_c;

  assign ba_c  = sd.sd_ba;
  assign dqm_c = {sd.sd_dqmh, sd.sd_dqml};

  // Command decode from {ncs,nras,ncas,nwe}; burst terminate and inhibit are NOPs.
  always_comb begin
    cmd_c = CMD_NOP;
    if (!sd.sd_ncs) begin
      case ({sd.sd_nras, sd.sd_ncas, sd.sd_nwe})
        3'b011:  cmd_c = CMD_ACT;
        3'b101:  cmd_c = CMD_RD;
        3'b100:  cmd_c = CMD_WR;
        3'b010:  cmd_c = CMD_PRE;
        3'b001:  cmd_c = CMD_REF;
        3'b000:  cmd_c = CMD_MRS;
        default: cmd_c = CMD_NOP;
      endcase
    end
  end

  // A bank in its last precharge cycle is already usable by this edge's command.
  always_comb begin
    bank_idle_c = '0;
    for (int b = 0; b < NB; b++) begin
      bank_idle_c[b] = (bank_st[b] == B_IDLE) ||
                       ((bank_st[b] == B_PRECHG) && (pre_cnt[b] == CW'(1)));
    end
  end

  assign rw_c      = (cmd_c == CMD_RD) || (cmd_c == CMD_WR);
  assign mode_ok_c = (sd.sd_a[2:0] == 3'd0) && ((sd.sd_a[6:4] == 3'd2) || (sd.sd_a[6:4] == 3'd3));

  // Violations raised by the command presented at this edge.
  always_comb begin
    viol_c    = '0;
    viol_c[0] = (rw_c || (cmd_c == CMD_ACT)) && !init_done;
    viol_c[1] = rw_c && (act_age[ba_c] < CW'(T_RCD));
    viol_c[2] = (cmd_c == CMD_ACT) && (last_ba != ba_c) && (rrd_age < CW'(T_RRD));
    viol_c[3] = (cmd_c == CMD_ACT) && (!bank_idle_c[ba_c] || (act_age[ba_c] < CW'(T_RC)));
    viol_c[4] = rw_c && (bank_st[ba_c] != B_ACTIVE);
    viol_c[5] = ((cmd_c == CMD_REF) || (cmd_c == CMD_MRS)) && (bank_idle_c != '1);
    viol_c[6] = init_done && (cmd_c != CMD_REF) && (ref_age >= RW'(T_REF_MAX));
    viol_c[7] = ((cmd_c == CMD_MRS) && !mode_ok_c) || ((cmd_c == CMD_WR) && out_v);
  end

`ifdef SDRAM_CHIP_MODEL_STRICT_EN
  localparam logic [7:0] DISCARD_MASK = 8'h3B;
  assign exec_c = ~|(viol_c & DISCARD_MASK);
`else
  assign exec_c = 1'b1;
`endif

  assign rd_exec_c = exec_c && (cmd_c == CMD_RD);
  assign wr_exec_c = exec_c && (cmd_c == CMD_WR) && !reset;
  // Low MEM_AW bits of {ba, row, col}; upper address bits alias.
  assign idx_c     = MEM_AW'({ba_c, bank_row[ba_c], sd.sd_a[8:0]});
  assign rd_word_c = mem[idx_c];

  // Backing array: not reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_exec_c) begin
      if (!sd.sd_dqml) mem[idx_c][7:0]  <= sd.dq_in[7:0];
      if (!sd.sd_dqmh) mem[idx_c][15:8] <= sd.dq_in[15:8];
    end
  end

  // Bank state machines, timing ages, refresh watchdog and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NB; b++) begin
        bank_st[b]  <= B_IDLE;
        bank_row[b] <= '0;
        ap_cnt[b]   <= '0;
        pre_cnt[b]  <= '0;
        act_age[b]  <= '1;
      end
      ap_pend       <= '0;
      rrd_age       <= '1;
      last_ba       <= '0;
      cl3           <= 1'b1;
      ref_age       <= '0;
      init_done     <= 1'b0;
      err           <= '0;
      refresh_count <= '0;
    end else begin
      err <= err | viol_c;
      if (rrd_age != '1) rrd_age <= rrd_age + CW'(1);
      if (init_done && (ref_age != '1)) ref_age <= ref_age + RW'(1);

      for (int b = 0; b < NB; b++) begin
        if (act_age[b] != '1) act_age[b] <= act_age[b] + CW'(1);
        case (bank_st[b])
          B_PRECHG: begin
            if (pre_cnt[b] <= CW'(1)) bank_st[b] <= B_IDLE;
            else                      pre_cnt[b] <= pre_cnt[b] - CW'(1);
          end
          B_ACTIVE: begin
            if (ap_pend[b]) begin
              if (ap_cnt[b] <= CW'(1)) begin
                bank_st[b] <= B_PRECHG;
                pre_cnt[b] <= CW'(T_RP);
                ap_pend[b] <= 1'b0;
              end else begin
                ap_cnt[b] <= ap_cnt[b] - CW'(1);
              end
            end
          end
          default: ;
        endcase
      end

      // Command effects override the background timer updates above.
      if (exec_c) begin
        case (cmd_c)
          CMD_ACT: begin
            bank_st[ba_c]  <= B_ACTIVE;
            bank_row[ba_c] <= sd.sd_a;
            ap_pend[ba_c]  <= 1'b0;
            act_age[ba_c]  <= CW'(1);
            rrd_age        <= CW'(1);
            last_ba        <= ba_c;
          end
          CMD_RD, CMD_WR: begin
            // Auto-precharge: reads start precharging next edge, writes after T_WR.
            if (sd.sd_a[10]) begin
              ap_pend[ba_c] <= 1'b1;
              ap_cnt[ba_c]  <= (cmd_c == CMD_RD) ? CW'(1) : CW'(T_WR);
            end
          end
          CMD_PRE: begin
            for (int b = 0; b < NB; b++) begin
              if ((sd.sd_a[10] || (2'(b) == ba_c)) && (bank_st[b] == B_ACTIVE)) begin
                bank_st[b] <= B_PRECHG;
                pre_cnt[b] <= CW'(T_RP);
                ap_pend[b] <= 1'b0;
              end
            end
          end
          CMD_REF: begin
            refresh_count <= refresh_count + 16'd1;
            ref_age       <= '0;
          end
          CMD_MRS: begin
            init_done <= 1'b1;
            cl3       <= !(mode_ok_c && (sd.sd_a[6:4] == 3'd2));
          end
          default: ;
        endcase
      end
    end
  end

  // Read pipeline: DQM is folded in at edge E+CL-2, output taken at edge E+CL.
  assign src_v_c = cl3 ? p_v[2] : p_v[1];
  assign src_d_c = cl3 ? p_d[2] : p_d[1];
  assign src_m_c = cl3 ? p_m[2] : p_m[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      p_v       <= '0;
      out_v     <= 1'b0;
      sd.dq_out <= '0;
      sd.dq_oe  <= '0;
      for (int s = 0; s < 3; s++) begin
        p_d[s] <= '0;
        p_m[s] <= '0;
      end
    end else begin
      p_v    <= {p_v[1:0], rd_exec_c};
      p_d[0] <= rd_word_c;
      p_d[1] <= p_d[0];
      p_d[2] <= p_d[1];
      p_m[0] <= cl3 ? 2'b00 : dqm_c;
      p_m[1] <= cl3 ? dqm_c : p_m[0];
      p_m[2] <= p_m[1];
      out_v  <= src_v_c;
      if (src_v_c) begin
        sd.dq_oe  <= ~src_m_c;
        sd.dq_out <= {src_m_c[1] ? 8'h00 : src_d_c[15:8], src_m_c[0] ? 8'h00 : src_d_c[7:0]};
      end else begin
        sd.dq_oe  <= 2'b00;
        sd.dq_out <= 16'h0000;
      end
    end
  end
endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed self-checking bench for sdram_chip_model: init sequence, read/write
// data path with byte masks and CAS latency 3 and 2, timing violations,
// refresh watchdog and mode-register checks.
module tb_sdram_chip_model;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
`ifdef SDRAM_CHIP_MODEL_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        init_done;
  logic [7:0]  err;
  logic [15:0] refresh_count;
  int          tests;
  int          fails;

  sdram_chip_model_if sd_if ();

  sdram_chip_model dut (
    .clk           (clk),
    .reset         (reset),
    .sd            (sd_if),
    .init_done     (init_done),
    .err           (err),
    .refresh_count (refresh_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for one cycle; returns 1 ns after the sampling edge.
  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [1:0] dqm, input logic [15:0] d);
    {sd_if.sd_ncs, sd_if.sd_nras, sd_if.sd_ncas, sd_if.sd_nwe} = c;
    sd_if.sd_ba = ba;
    sd_if.sd_a  = a;
    {sd_if.sd_dqmh, sd_if.sd_dqml} = dqm;
    sd_if.dq_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cmd(C_NOP, 2'd0, 13'd0, 2'b00, 16'd0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop(2);
    reset = 1'b0;
  endtask

  // Ends on the LOAD_MODE edge; the last AUTO_REFRESH is one edge earlier.
  task automatic init_seq(input logic [12:0] mode);
    cmd(C_PRE, 2'd0, 13'h0400, 2'b00, 16'd0);
    nop(3);
    cmd(C_REF, 2'd0, 13'd0, 2'b00, 16'd0);
    cmd(C_REF, 2'd0, 13'd0, 2'b00, 16'd0);
    cmd(C_MRS, 2'd0, mode, 2'b00, 16'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Reset values
    reset = 1'b1;
    nop(2);
    check("rst_dq_out", 32'(sd_if.dq_out), 32'h0);
    check("rst_dq_oe", 32'(sd_if.dq_oe), 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_refresh_count", 32'(refresh_count), 32'h0);
    reset = 1'b0;

    // Init sequence, CL=3
    init_seq(13'h0230);
    nop(1);
    check("init_done", 32'(init_done), 32'h1);
    check("init_refresh_count", 32'(refresh_count), 32'd2);
    check("init_err", 32'(err), 32'h0);

    // Write with auto-precharge, reopen after recovery, read with CL=3
    cmd(C_ACT, 2'd3, 13'h1F0, 2'b00, 16'd0);
    nop(2);
    cmd(C_WR, 2'd3, 13'h0405, 2'b00, 16'hBEEF);
    nop(7);
    cmd(C_ACT, 2'd3, 13'h1F0, 2'b00, 16'd0);
    nop(2);
    cmd(C_RD, 2'd3, 13'h0005, 2'b00, 16'd0);
    nop(1);
    nop(1);
    check("rd_cl3_early_oe", 32'(sd_if.dq_oe), 32'h0);
    nop(1);
    check("rd_cl3_data", 32'(sd_if.dq_out), 32'hBEEF);
    check("rd_cl3_oe", 32'(sd_if.dq_oe), 32'h3);
    nop(1);
    check("rd_cl3_hold_oe", 32'(sd_if.dq_oe), 32'h0);

    // Byte-masked write, then masked and back-to-back reads
    cmd(C_WR, 2'd3, 13'h0005, 2'b10, 16'h1234);
    cmd(C_WR, 2'd3, 13'h0006, 2'b00, 16'h5A5A);
    cmd(C_RD, 2'd3, 13'h0005, 2'b00, 16'd0);
    nop(3);
    check("mask_wr_data", 32'(sd_if.dq_out), 32'hBE34);
    check("mask_wr_oe", 32'(sd_if.dq_oe), 32'h3);
    cmd(C_RD, 2'd3, 13'h0005, 2'b00, 16'd0);
    cmd(C_RD, 2'd3, 13'h0006, 2'b01, 16'd0);
    cmd(C_NOP, 2'd0, 13'd0, 2'b00, 16'd0);
    nop(1);
    check("dqml_rd_data", 32'(sd_if.dq_out), 32'hBE00);
    check("dqml_rd_oe", 32'(sd_if.dq_oe), 32'h2);
    nop(1);
    check("pipe_rd_data", 32'(sd_if.dq_out), 32'h5A5A);
    check("pipe_rd_oe", 32'(sd_if.dq_oe), 32'h3);
    check("datapath_err", 32'(err), 32'h0);
    cmd(C_PRE, 2'd0, 13'h0400, 2'b00, 16'd0);

    // READ two cycles after ACTIVE; row 0 col 5 aliases the word written above
    do_reset();
    init_seq(13'h0230);
    nop(1);
    check("reinit_err", 32'(err), 32'h0);
    cmd(C_ACT, 2'd0, 13'h0000, 2'b00, 16'd0);
    nop(1);
    cmd(C_RD, 2'd0, 13'h0005, 2'b00, 16'd0);
    nop(3);
    check("trcd_err", 32'(err), 32'h02);
    check("trcd_oe", 32'(sd_if.dq_oe), 32'(STRICT ? 2'b00 : 2'b11));
    check("trcd_data", 32'(sd_if.dq_out), 32'(STRICT ? 16'h0000 : 16'hBE34));

    // ACTIVE to another bank too soon, then refresh with a bank open
    do_reset();
    init_seq(13'h0230);
    nop(1);
    cmd(C_ACT, 2'd0, 13'h0000, 2'b00, 16'd0);
    cmd(C_ACT, 2'd1, 13'h0000, 2'b00, 16'd0);
    nop(1);
    check("trrd_err", 32'(err), 32'h04);
    cmd(C_REF, 2'd0, 13'd0, 2'b00, 16'd0);
    nop(1);
    check("ref_open_err", 32'(err), 32'h24);
    check("ref_open_count", 32'(refresh_count), 32'(STRICT ? 16'd2 : 16'd3));

    // Refresh watchdog boundary: 1100 cycles fine, 1101 flags
    do_reset();
    init_seq(13'h0230);
    nop(1100);
    check("wdog_edge_err", 32'(err), 32'h0);
    nop(1);
    check("wdog_err", 32'(err), 32'h40);

    // Unsupported mode (burst length 2)
    cmd(C_MRS, 2'd0, 13'h0031, 2'b00, 16'd0);
    nop(1);
    check("bad_mode_err", 32'(err), 32'hC0);
    check("bad_mode_init", 32'(init_done), 32'h1);

    // CL=2 read, then a write colliding with the read-out slot
    do_reset();
    init_seq(13'h0020);
    nop(1);
    check("cl2_init_err", 32'(err), 32'h0);
    cmd(C_ACT, 2'd3, 13'h1F0, 2'b00, 16'd0);
    nop(2);
    cmd(C_RD, 2'd3, 13'h0005, 2'b00, 16'd0);
    nop(1);
    check("rd_cl2_early_oe", 32'(sd_if.dq_oe), 32'h0);
    nop(1);
    check("rd_cl2_data", 32'(sd_if.dq_out), 32'hBE34);
    check("rd_cl2_oe", 32'(sd_if.dq_oe), 32'h3);
    cmd(C_WR, 2'd3, 13'h0005, 2'b00, 16'h1111);
    nop(1);
    check("conflict_err", 32'(err), 32'h80);
    cmd(C_RD, 2'd3, 13'h0005, 2'b00, 16'd0);
    nop(2);
    check("conflict_wr_data", 32'(sd_if.dq_out), 32'h1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
